// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word on valid/ready and
// shifts it out one bit per clock, flagging the first and last bit of each word.
module piso_shift_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             in_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [CW-1:0]    cnt_q;

    logic in_shift, last_bit, accept;
    logic [WIDTH-1:0] sreg_shifted;

    assign in_shift = (state_q == SHIFT);
    assign last_bit = in_shift && (cnt_q == LAST);
    // Ready never looks at in_valid, so upstream sees no combinational loop.
    assign in_ready = (state_q == IDLE) || last_bit;
    assign accept   = in_valid && in_ready;

    // Zero fill leaves the register empty once the last bit has gone out.
    assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, sreg_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        sreg_q  <= parallel_in;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        cnt_q <= '0;
                        if (accept) begin
                            sreg_q <= parallel_in;
                        end else begin
                            sreg_q  <= sreg_shifted;
                            state_q <= IDLE;
                        end
                    end else begin
                        sreg_q <= sreg_shifted;
                        cnt_q  <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    sreg_q  <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // All outputs decode registered state only; no path from inputs.
    assign serial_valid = in_shift;
    assign busy         = in_shift;
    assign serial_out   = in_shift && (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
    assign frame_start  = in_shift && (cnt_q == '0);
    assign frame_end    = last_bit;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: a 4-bit LSB-first and an 8-bit MSB-first instance,
// checked every cycle against a queue of expected bits with frame markers.
module tb_piso_shift_tx;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       iv4, r4, so4, sv4, fs4, fe4, bz4;
    logic [3:0] d4;
    logic       iv8, r8, so8, sv8, fs8, fe8, bz8;
    logic [7:0] d8;

    piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(iv4), .parallel_in(d4),
        .in_ready(r4), .serial_out(so4), .serial_valid(sv4),
        .frame_start(fs4), .frame_end(fe4), .busy(bz4)
    );

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .parallel_in(d8),
        .in_ready(r8), .serial_out(so8), .serial_valid(sv8),
        .frame_start(fs8), .frame_end(fe8), .busy(bz8)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Each pending bit: {data, first, last}; front is the bit on the wire now.
    typedef logic [2:0] ent_t;
    ent_t q4[$];
    ent_t q8[$];

    logic [31:0] bits4, bits8;
    int          nb4, nb8;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {serial_valid, serial_out, frame_start, frame_end, busy, in_ready}.
    function automatic logic [5:0] expv(input int sz, input ent_t f);
        if (sz == 0) return 6'b000001;
        return {1'b1, f[2], f[1], f[0], 1'b1, sz == 1};
    endfunction

    task automatic step();
        bit a4, a8;
        @(posedge clk);
        if (reset) begin
            q4.delete();
            q8.delete();
        end else begin
            // A transmitter can take a word when at most its final bit is pending.
            a4 = iv4 && (q4.size() <= 1);
            a8 = iv8 && (q8.size() <= 1);
            if (q4.size() > 0) void'(q4.pop_front());
            if (q8.size() > 0) void'(q8.pop_front());
            if (a4) for (int i = 0; i < 4; i++) q4.push_back({d4[i], i == 0, i == 3});
            if (a8) for (int i = 0; i < 8; i++) q8.push_back({d8[7-i], i == 0, i == 7});
        end
        @(negedge clk);
        chk("dut4", {26'd0, sv4, so4, fs4, fe4, bz4, r4},
            {26'd0, expv(q4.size(), q4.size() > 0 ? q4[0] : 3'b000)});
        chk("dut8", {26'd0, sv8, so8, fs8, fe8, bz8, r8},
            {26'd0, expv(q8.size(), q8.size() > 0 ? q8[0] : 3'b000)});
        if (sv4) begin bits4 = {bits4[30:0], so4}; nb4++; end
        if (sv8) begin bits8 = {bits8[30:0], so8}; nb8++; end
    endtask

    task automatic clr_log();
        bits4 = '0; nb4 = 0; bits8 = '0; nb8 = 0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b1;
        iv4 = 1'b1; d4 = 4'hF;
        iv8 = 1'b1; d8 = 8'hFF;
        clr_log();

        // Reset held with a valid word offered: nothing accepted, ready stays high.
        steps(3);
        iv4 = 1'b0; iv8 = 1'b0;
        reset = 1'b0;
        steps(2);

        // Single word 1011, LSB first.
        clr_log();
        d4 = 4'b1011; iv4 = 1'b1;
        step();
        iv4 = 1'b0;
        steps(5);
        chk("t2_bits", bits4, 32'b1101);
        chk("t2_count", nb4, 4);

        // Back-to-back words with the second offered on the last-bit cycle.
        clr_log();
        d4 = 4'b0001; iv4 = 1'b1;
        step();
        iv4 = 1'b0;
        steps(3);
        d4 = 4'b1001; iv4 = 1'b1;
        step();
        iv4 = 1'b0;
        steps(4);
        chk("t3_bits", bits4, 32'b10001001);
        chk("t3_count", nb4, 8);

        // Next word held valid for the whole first word; taken only at its end.
        clr_log();
        d4 = 4'b1100; iv4 = 1'b1;
        step();
        d4 = 4'b0110;
        steps(4);
        iv4 = 1'b0;
        steps(5);
        chk("t4_bits", bits4, 32'b00110110);
        chk("t4_count", nb4, 8);

        // Asynchronous reset mid-word clears outputs before the next edge.
        clr_log();
        d4 = 4'b0101; iv4 = 1'b1;
        d8 = 8'h3C;   iv8 = 1'b1;
        step();
        iv4 = 1'b0; iv8 = 1'b0;
        steps(2);
        reset = 1'b1;
        #1;
        chk("t5_async4", {26'd0, sv4, so4, fs4, fe4, bz4, r4}, 32'b000001);
        chk("t5_async8", {26'd0, sv8, so8, fs8, fe8, bz8, r8}, 32'b000001);
        step();
        reset = 1'b0;
        step();
        clr_log();
        d4 = 4'b0110; iv4 = 1'b1;
        step();
        iv4 = 1'b0;
        steps(5);
        chk("t5_bits", bits4, 32'b0110);
        chk("t5_count", nb4, 4);

        // MSB-first 8-bit word A5.
        clr_log();
        d8 = 8'hA5; iv8 = 1'b1;
        step();
        iv8 = 1'b0;
        steps(9);
        chk("t6_bits", bits8, 32'hA5);
        chk("t6_count", nb8, 8);

        // Random traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            iv4 = 1'($urandom_range(0, 1));
            d4  = 4'($urandom);
            iv8 = 1'($urandom_range(0, 1));
            d8  = 8'($urandom);
            reset = ($urandom_range(0, 63) == 0);
            step();
        end
        reset = 1'b0; iv4 = 1'b0; iv8 = 1'b0;
        steps(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
